// File: rtl/clk_div_multi.sv
// clk_div_multi: NUM_CH independent programmable clock dividers off the system clock.
// Each channel produces a registered divided clock level (clk_out) and a one-cycle
// strobe (tick) on the last cycle of every period. New divide ratios are staged in a
// per-channel pending slot and take over only at a period boundary (wrap, sync or
// while disabled), so clk_out never glitches.
// Optional feature macro: CLKDIV_DUTY_EN adds duty_val, a programmable high-phase
// length written together with the ratio; without it the high phase is div>>1.
module clk_div_multi #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sync,
    input  logic              div_wr,
    input  logic [3:0]        div_ch,
    input  logic [DIV_W-1:0]  div_val,
`ifdef CLKDIV_DUTY_EN
    input  logic [DIV_W-1:0]  duty_val,
`endif
    output logic              cfg_err,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] HI_RST   = DIV_W'(DEFAULT_DIV / 2);
    localparam logic [DIV_W-1:0] MIN_DIV  = DIV_W'(2);
    localparam logic [4:0]       NUM_CH_W = 5'(NUM_CH);

    // Per-channel state: counter, active ratio/high length, staged ratio/high length.
    logic [DIV_W-1:0]  cnt_q      [NUM_CH];
    logic [DIV_W-1:0]  cnt_d      [NUM_CH];
    logic [DIV_W-1:0]  div_q      [NUM_CH];
    logic [DIV_W-1:0]  div_d      [NUM_CH];
    logic [DIV_W-1:0]  hi_q       [NUM_CH];
    logic [DIV_W-1:0]  hi_d       [NUM_CH];
    logic [DIV_W-1:0]  pend_div_q [NUM_CH];
    logic [DIV_W-1:0]  pend_div_d [NUM_CH];
    logic [DIV_W-1:0]  pend_hi_q  [NUM_CH];
    logic [DIV_W-1:0]  pend_hi_d  [NUM_CH];
    logic [NUM_CH-1:0] pend_vld_q, pend_vld_d;
    logic [NUM_CH-1:0] clk_out_q, clk_out_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic              cfg_err_q, cfg_err_d;

    logic              restart;
    logic              wr_ch_ok;
    logic              wr_val_ok;
    logic [DIV_W-1:0]  wr_hi;
    logic [NUM_CH-1:0] wr_sel;
    logic [NUM_CH-1:0] wrap;

    // Disable and sync both hold every counter at the start of a fresh period.
    assign restart  = !en || sync;
    assign wr_ch_ok = {1'b0, div_ch} < NUM_CH_W;

`ifdef CLKDIV_DUTY_EN
    assign wr_hi     = duty_val;
    assign wr_val_ok = (div_val >= MIN_DIV) && (duty_val >= DIV_W'(1)) && (duty_val < div_val);
`else
    assign wr_hi     = div_val >> 1;
    assign wr_val_ok = div_val >= MIN_DIV;
`endif

    // Decode the accepted write target and each channel's last-cycle-of-period flag.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        wr_sel = '0;
        wrap   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_sel[i] = div_wr && wr_ch_ok && wr_val_ok && (div_ch == 4'(i));
            wrap[i]   = cnt_q[i] == (div_q[i] - DIV_W'(1));
        end
    end

    // Next-state: count, generate clk_out/tick, swap in a staged ratio at period boundaries.
    always_comb begin
        cnt_d      = cnt_q;
        div_d      = div_q;
        hi_d       = hi_q;
        pend_div_d = pend_div_q;
        pend_hi_d  = pend_hi_q;
        pend_vld_d = pend_vld_q;
        clk_out_d  = clk_out_q;
        tick_d     = tick_q;
        cfg_err_d  = div_wr && !(wr_ch_ok && wr_val_ok);
        for (int i = 0; i < NUM_CH; i++) begin
            // A write in this cycle goes into pending first, so a same-cycle wrap or sync uses it.
            if (wr_sel[i]) begin
                pend_div_d[i] = div_val;
                pend_hi_d[i]  = wr_hi;
                pend_vld_d[i] = 1'b1;
            end
            if (restart) begin
                cnt_d[i]     = '0;
                clk_out_d[i] = 1'b0;
                tick_d[i]    = 1'b0;
            end else begin
                clk_out_d[i] = cnt_q[i] < hi_q[i];
                tick_d[i]    = wrap[i];
                cnt_d[i]     = wrap[i] ? '0 : cnt_q[i] + DIV_W'(1);
            end
            // The counter restarts from zero here, so it can never exceed the new div-1.
            if ((restart || wrap[i]) && pend_vld_d[i]) begin
                div_d[i]      = pend_div_d[i];
                hi_d[i]       = pend_hi_d[i];
                pend_vld_d[i] = 1'b0;
            end
        end
    end

    // State registers with asynchronous reset to the default ratio.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: these per-channel arrays are control registers, not RAM, so every entry is reset.
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]      <= '0;
                div_q[i]      <= DIV_RST;
                hi_q[i]       <= HI_RST;
                pend_div_q[i] <= DIV_RST;
                pend_hi_q[i]  <= HI_RST;
            end
            pend_vld_q <= '0;
            clk_out_q  <= '0;
            tick_q     <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            hi_q       <= hi_d;
            pend_div_q <= pend_div_d;
            pend_hi_q  <= pend_hi_d;
            pend_vld_q <= pend_vld_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi (default build, CLKDIV_DUTY_EN undefined).
// A period-level model (period start edge + active ratio per channel) predicts every
// output on every cycle; directed checks pin period lengths, duty and alignment.
module tb_clk_div_multi;

    localparam int NUM_CH      = 4;
    localparam int DIV_W       = 16;
    localparam int DEFAULT_DIV = 100;

    logic              clk;
    logic              rst;
    logic              en;
    logic              sync;
    logic              div_wr;
    logic [3:0]        div_ch;
    logic [DIV_W-1:0]  div_val;
    logic              cfg_err;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;

    int checks = 0;
    int errors = 0;
    int err_cnt = 0;

    clk_div_multi #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .sync    (sync),
        .div_wr  (div_wr),
        .div_ch  (div_ch),
        .div_val (div_val),
        .cfg_err (cfg_err),
        .clk_out (clk_out),
        .tick    (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- period-level model ----------------
    // Each channel remembers the edge at which its current period restarted and its ratio N.
    // On an active edge e the output reflects offset = e - start - 1 within the period:
    // clk_out high for the first N/2 offsets, tick on offset N-1.
    int edge_no;
    int per_start [NUM_CH];
    int n_cur     [NUM_CH];
    int n_pend    [NUM_CH];
    bit pend_v    [NUM_CH];
    bit exp_clk   [NUM_CH];
    bit exp_tick  [NUM_CH];
    bit exp_err;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_no = 0;
            exp_err = 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                per_start[c] = -1;
                n_cur[c]     = DEFAULT_DIV;
                n_pend[c]    = DEFAULT_DIV;
                pend_v[c]    = 1'b0;
                exp_clk[c]   = 1'b0;
                exp_tick[c]  = 1'b0;
            end
        end else begin
            exp_err = div_wr && ((int'(div_ch) >= NUM_CH) || (int'(div_val) < 2));
            for (int c = 0; c < NUM_CH; c++) begin
                int off;
                if (div_wr && int'(div_ch) == c && int'(div_val) >= 2) begin
                    pend_v[c] = 1'b1;
                    n_pend[c] = int'(div_val);
                end
                if (!en || sync) begin
                    per_start[c] = edge_no;
                    exp_clk[c]   = 1'b0;
                    exp_tick[c]  = 1'b0;
                    if (pend_v[c]) begin
                        n_cur[c]  = n_pend[c];
                        pend_v[c] = 1'b0;
                    end
                end else begin
                    off         = edge_no - per_start[c] - 1;
                    exp_clk[c]  = off < (n_cur[c] / 2);
                    exp_tick[c] = off == n_cur[c] - 1;
                    if (exp_tick[c]) begin
                        per_start[c] = edge_no;
                        if (pend_v[c]) begin
                            n_cur[c]  = n_pend[c];
                            pend_v[c] = 1'b0;
                        end
                    end
                end
            end
            edge_no++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model on each falling edge outside reset.
    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("model_cfg_err", int'(cfg_err), int'(exp_err));
                for (int c = 0; c < NUM_CH; c++) begin
                    check($sformatf("model_ch%0d_clk_out", c), int'(clk_out[c]), int'(exp_clk[c]));
                    check($sformatf("model_ch%0d_tick", c), int'(tick[c]), int'(exp_tick[c]));
                end
            end
        end
    endtask

    // Count cfg_err pulses for the rejected-write test.
    always @(negedge clk) begin
        if (!rst && cfg_err) err_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic wr(input int ch, input int val);
        div_wr  = 1'b1;
        div_ch  = 4'(ch);
        div_val = DIV_W'(val);
        @(negedge clk);
        div_wr  = 1'b0;
    endtask

    // Falling edges until the next tick on channel ch (bounded).
    task automatic wait_tick(input int ch, input int budget, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!tick[ch] && cycles < budget);
        if (!tick[ch]) check($sformatf("timeout_tick_ch%0d", ch), 0, 1);
    endtask

    task automatic count_high(input int ch, input int len, output int highs);
        highs = 0;
        repeat (len) begin
            @(negedge clk);
            highs += int'(clk_out[ch]);
        end
    endtask

    initial begin
        int c;
        int h;
        int err_before;

        rst     = 1'b1;
        en      = 1'b1;
        sync    = 1'b0;
        div_wr  = 1'b0;
        div_ch  = '0;
        div_val = '0;
        fork
            compare_loop();
        join_none

        // Reset state, held 1 us.
        #1000;
        check("reset_clk_out", int'(clk_out), 0);
        check("reset_tick", int'(tick), 0);
        check("reset_cfg_err", int'(cfg_err), 0);
        @(negedge clk);
        rst = 1'b0;

        // 1: default ratio 100, 50 high / 50 low.
        wait_tick(0, 200, c);
        check("t1_first_tick_delay", c, 100);
        wait_tick(0, 200, c);
        check("t1_ch0_period", c, 100);
        count_high(3, 100, h);
        check("t1_ch3_high_cycles", h, 50);
        check("t1_ch3_tick_at_end", int'(tick[3]), 1);

        // 2: ch1 N=4 written at cnt=30; finishes its 100 period first.
        repeat (30) @(negedge clk);
        wr(1, 4);
        wait_tick(1, 200, c);
        check("t2_ch1_rest_of_period", c, 69);
        check("t2_ch0_aligned_tick", int'(tick[0]), 1);
        wait_tick(1, 200, c);
        check("t2_ch1_period", c, 4);
        count_high(1, 4, h);
        check("t2_ch1_high_cycles", h, 2);

        // 3: ch2 N=3, odd ratio -> 1 high / 2 low.
        wr(2, 3);
        wait_tick(2, 200, c);
        wait_tick(2, 200, c);
        check("t3_ch2_period", c, 3);
        count_high(2, 3, h);
        check("t3_ch2_high_cycles", h, 1);

        // 4: rejected writes (N=1, channel 7) leave ratios unchanged.
        err_before = err_cnt;
        wr(0, 1);
        wr(7, 50);
        @(negedge clk);
        check("t4_cfg_err_pulses", err_cnt - err_before, 2);
        wait_tick(0, 200, c);
        wait_tick(0, 200, c);
        check("t4_ch0_period_kept", c, 100);
        wait_tick(1, 200, c);
        check("t4_ch1_period_kept", c, 4);

        // 5: ch0 N=4, ch1 N=6, then sync -> aligned, joint tick 12 edges after sync.
        wr(0, 4);
        wr(1, 6);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        check("t5_sync_low", int'(clk_out[1:0]), 0);
        @(negedge clk);
        check("t5_rise_together", int'(clk_out[1:0]), 3);
        c = 1;
        while (!(tick[0] && tick[1]) && c < 50) begin
            @(negedge clk);
            c++;
        end
        check("t5_joint_tick_edges", c, 12);

        // 6: en=0 mid-period, then async reset mid-period.
        repeat (3) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("t6_disabled_clk_out", int'(clk_out), 0);
        check("t6_disabled_tick", int'(tick), 0);
        repeat (4) @(negedge clk);
        en = 1'b1;
        repeat (37) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_rst_clk_out", int'(clk_out), 0);
        check("t6_async_rst_tick", int'(tick), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_tick(0, 200, c);
        check("t6_ch0_reverts_100", c, 100);
        check("t6_ch1_reverts_aligned", int'(tick[1]), 1);
        check("t6_ch2_reverts_aligned", int'(tick[2]), 1);
        wait_tick(1, 200, c);
        check("t6_ch1_period_100", c, 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
